// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle control FSM for the single-issue RISC-V core. It takes the
//   6-bit ALUop from the instruction decoder and steps each instruction through
//   fetch, decode, execute, memory and write-back. It drives the PC, IR,
//   register-file and data-memory enables, and it handshakes with the
//   instruction and data memories through their ready inputs. It holds no
//   datapath registers. The only internal copy is the ALUop, which is latched
//   in DECODE.
//
// Build option:
//   CTRL_ILLEGAL_TRAP_EN  When defined, an illegal ALUop seen in DECODE halts
//                         the core and sets illegal_o. When undefined, an
//                         illegal op runs as a NOP (PC+4 only) and illegal_o
//                         is tied to 0.
//
// Parameters:
//   MEM_TIMEOUT    Maximum number of MEM cycles without dmem_ready_i before
//                  the core halts with a timeout (1..255).
//
// Ports:
//   clk            Clock. All state updates happen on the rising edge.
//   rst            Synchronous reset, active high.
//   alu_op_i       Decoder ALUop: 1 add, 2 sub, 3 sll, 4 jal, 5 addi, 6 and,
//                  7 or, 8 xor, 9 blt, 10 beq, 11 srl, 12 lw, 13 sw.
//                  0 and 14..63 are illegal.
//   br_taken_i     Branch condition from the ALU, sampled in EXEC.
//   imem_ready_i   Instruction word is valid this cycle.
//   dmem_ready_i   Data access completes this cycle.
//   imem_req_o     Instruction fetch request.
//   ir_we_o        Latch the instruction register.
//   pc_we_o        Update the PC.
//   pc_src_o       PC source: 0 PC+4, 1 branch target, 2 jal target.
//   reg_we_o       Register-file write enable.
//   wb_sel_o       Write-back source: 0 ALU result, 1 load data, 2 PC+4.
//   dmem_re_o      Data read request.
//   dmem_we_o      Data write request.
//   state_o        Current state, for debug.
//   halt_o         Core halted. Sticky until rst.
//   timeout_o      Halted because of a data-memory timeout. Sticky.
//   illegal_o      Halted on an illegal ALUop. Sticky.
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] alu_op_i,
  input  logic       br_taken_i,
  input  logic       imem_ready_i,
  input  logic       dmem_ready_i,
  output logic       imem_req_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic       reg_we_o,
  output logic [1:0] wb_sel_o,
  output logic       dmem_re_o,
  output logic       dmem_we_o,
  output logic [2:0] state_o,
  output logic       halt_o,
  output logic       timeout_o,
  output logic       illegal_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [5:0] OP_JAL = 6'd4;
  localparam logic [5:0] OP_BLT = 6'd9;
  localparam logic [5:0] OP_BEQ = 6'd10;
  localparam logic [5:0] OP_LW  = 6'd12;
  localparam logic [5:0] OP_SW  = 6'd13;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JAL = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_LD  = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // This is the value of the wait counter on the last MEM cycle allowed
  // before the timeout. The counter starts at 0 on the first MEM cycle.
  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [5:0] op_q;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_q, illegal_d;
`endif

  logic       imem_req, ir_we, pc_we, reg_we, dmem_re, dmem_we;
  logic [1:0] pc_src, wb_sel;

  // These are the ALU-class ops that finish in write-back.
  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      6'd1, 6'd2, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd11: is_alu_op = 1'b1;
      default:                                         is_alu_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    is_legal = (op >= 6'd1) && (op <= 6'd13);
  endfunction

  // State and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // The ALUop register is data. It is only written in DECODE, so it needs no
  // reset, and it is never read before that write.
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) begin
      op_q <= alu_op_i;
    end
  end

  // Next-state and enable decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SEQ;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready_i) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!is_legal(alu_op_i)) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
`else
        state_d = S_EXEC;
`endif
      end

      S_EXEC: begin
        if (op_q == OP_BEQ || op_q == OP_BLT) begin
          pc_we   = 1'b1;
          pc_src  = br_taken_i ? PC_BR : PC_SEQ;
          state_d = S_FETCH;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          cnt_d   = 8'd0;
          state_d = S_MEM;
        end else if (is_alu_op(op_q) || op_q == OP_JAL) begin
          state_d = S_WB;
        end else begin
          // An illegal op that reaches this state runs as a NOP: it only
          // advances the PC.
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        dmem_re = (op_q == OP_LW);
        dmem_we = (op_q == OP_SW);
        // Ready is checked before the limit. A ready that arrives on the
        // final allowed cycle still completes the access normally.
        if (dmem_ready_i) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (cnt_q >= CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        if (op_q == OP_JAL) begin
          wb_sel = WB_PC4;
          pc_src = PC_JAL;
        end else if (op_q == OP_LW) begin
          wb_sel = WB_LD;
        end
        state_d = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Every output is forced low while rst is asserted. This keeps a reset
  // issued mid-instruction from leaking a partial enable.
  always_comb begin
    imem_req_o = imem_req & ~rst;
    ir_we_o    = ir_we    & ~rst;
    pc_we_o    = pc_we    & ~rst;
    pc_src_o   = rst ? 2'd0 : pc_src;
    reg_we_o   = reg_we   & ~rst;
    wb_sel_o   = rst ? 2'd0 : wb_sel;
    dmem_re_o  = dmem_re  & ~rst;
    dmem_we_o  = dmem_we  & ~rst;
    state_o    = rst ? 3'd0 : state_q;
    halt_o     = (state_q == S_HALT) & ~rst;
    timeout_o  = timeout_q & ~rst;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_o  = illegal_q & ~rst;
`else
    illegal_o  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam int unsigned MEM_TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] alu_op;
  logic       br_taken, imem_ready, dmem_ready;
  logic       imem_req, ir_we, pc_we, reg_we, dmem_re, dmem_we;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] state;
  logic       halt, timeout, illegal;

  int n_chk  = 0;
  int n_pass = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_op_i     (alu_op),
    .br_taken_i   (br_taken),
    .imem_ready_i (imem_ready),
    .dmem_ready_i (dmem_ready),
    .imem_req_o   (imem_req),
    .ir_we_o      (ir_we),
    .pc_we_o      (pc_we),
    .pc_src_o     (pc_src),
    .reg_we_o     (reg_we),
    .wb_sel_o     (wb_sel),
    .dmem_re_o    (dmem_re),
    .dmem_we_o    (dmem_we),
    .state_o      (state),
    .halt_o       (halt),
    .timeout_o    (timeout),
    .illegal_o    (illegal)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {state, req, ir_we, pc_we, pc_src, reg_we, wb_sel, re, we, halt, timeout, illegal}.
  logic [15:0] obs;
  assign obs = {state, imem_req, ir_we, pc_we, pc_src, reg_we, wb_sel,
                dmem_re, dmem_we, halt, timeout, illegal};

  localparam logic [15:0] REQ  = 16'h1000;
  localparam logic [15:0] IRWE = 16'h0800;
  localparam logic [15:0] PCWE = 16'h0400;
  localparam logic [15:0] RWE  = 16'h0080;
  localparam logic [15:0] RE   = 16'h0010;
  localparam logic [15:0] WE   = 16'h0008;
  localparam logic [15:0] HLT  = 16'h0004;
  localparam logic [15:0] TMO  = 16'h0002;
  localparam logic [15:0] ILL  = 16'h0001;

  function automatic logic [15:0] st(input logic [2:0] s);
    return {s, 13'b0};
  endfunction
  function automatic logic [15:0] ps(input logic [1:0] p);
    return {6'b0, p, 8'b0};
  endfunction
  function automatic logic [15:0] ws(input logic [1:0] w);
    return {9'b0, w, 5'b0};
  endfunction
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock cycle: drive the inputs, compare on the falling edge, then step
  // to just after the next rising edge.
  task automatic cyc(input string tag, input logic ir, input logic dr,
                     input logic br, input logic [5:0] op, input logic [15:0] exp);
    imem_ready = ir; dmem_ready = dr; br_taken = br; alu_op = op;
    @(negedge clk);
    chk(tag, obs, exp);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc("reset0", rb(), rb(), rb(), rop(), 16'h0);
    cyc("reset1", rb(), rb(), rb(), rop(), 16'h0);
    rst = 1'b0;
  endtask

  // Expected cycle-by-cycle trace of one instruction, built from its class:
  //   fw = number of imem wait cycles
  //   mw = number of dmem wait cycles (>= MEM_TO means ready never comes)
  task automatic run_instr(input logic [5:0] op, input int fw, input logic br,
                           input int mw, output bit halted);
    bit legal, is_br, is_mem, is_lw, is_jal;
    legal  = (op >= 6'd1 && op <= 6'd13);
    is_br  = (op == 6'd9 || op == 6'd10);
    is_lw  = (op == 6'd12);
    is_mem = is_lw || (op == 6'd13);
    is_jal = (op == 6'd4);
    halted = 1'b0;
    for (int i = 0; i < fw; i++)
      cyc("fetch_wait", 1'b0, rb(), rb(), rop(), st(3'd0) | REQ);
    cyc("fetch", 1'b1, rb(), rb(), rop(), st(3'd0) | REQ | IRWE);
    cyc("decode", rb(), rb(), rb(), op, st(3'd1));
    if (!legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      cyc("trap0", rb(), rb(), rb(), rop(), st(3'd7) | HLT | ILL);
      cyc("trap1", rb(), rb(), rb(), rop(), st(3'd7) | HLT | ILL);
      halted = 1'b1;
`else
      cyc("nop_exec", rb(), rb(), rb(), rop(), st(3'd2) | PCWE | ps(2'd0));
`endif
    end else if (is_br) begin
      cyc("branch", rb(), rb(), br, rop(), st(3'd2) | PCWE | ps(br ? 2'd1 : 2'd0));
    end else begin
      cyc("exec", rb(), rb(), rb(), rop(), st(3'd2));
      if (!is_mem) begin
        cyc("wb", rb(), rb(), rb(), rop(),
            st(3'd4) | RWE | PCWE | ps(is_jal ? 2'd2 : 2'd0) | ws(is_jal ? 2'd2 : 2'd0));
      end else begin
        logic [15:0] rq;
        rq = is_lw ? RE : WE;
        if (mw >= int'(MEM_TO)) begin
          for (int i = 0; i < int'(MEM_TO); i++)
            cyc("mem_wait", rb(), 1'b0, rb(), rop(), st(3'd3) | rq);
          cyc("timeout0", rb(), rb(), rb(), rop(), st(3'd7) | HLT | TMO);
          cyc("timeout1", rb(), rb(), rb(), rop(), st(3'd7) | HLT | TMO);
          halted = 1'b1;
        end else begin
          for (int i = 0; i < mw; i++)
            cyc("mem_wait", rb(), 1'b0, rb(), rop(), st(3'd3) | rq);
          if (is_lw) begin
            cyc("mem_done_lw", rb(), 1'b1, rb(), rop(), st(3'd3) | RE);
            cyc("wb_lw", rb(), rb(), rb(), rop(), st(3'd4) | RWE | PCWE | ws(2'd1));
          end else begin
            cyc("mem_done_sw", rb(), 1'b1, rb(), rop(), st(3'd3) | WE | PCWE);
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    rst = 1'b1; alu_op = 6'd0; br_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Directed cases
    run_instr(6'd1, 0, 1'b0, 0, h);             // add: 4 cycles
    run_instr(6'd10, 0, 1'b1, 0, h);            // beq, branch taken
    run_instr(6'd10, 0, 1'b0, 0, h);            // beq, branch not taken
    run_instr(6'd4, 1, 1'b0, 0, h);             // jal
    run_instr(6'd12, 0, 1'b0, 3, h);            // lw, 3 wait cycles
    run_instr(6'd13, 0, 1'b0, 14, h);           // sw, ready arrives on the limit cycle
    run_instr(6'd13, 0, 1'b0, 100, h);          // sw, ready never arrives
    if (h) do_reset();
    run_instr(6'd0, 0, 1'b0, 0, h);             // illegal op
    if (h) do_reset();

    // Reset asserted while a lw is in MEM
    cyc("fetch", 1'b1, 1'b0, 1'b0, 6'd0, st(3'd0) | REQ | IRWE);
    cyc("decode", 1'b0, 1'b0, 1'b0, 6'd12, st(3'd1));
    cyc("exec", 1'b0, 1'b0, 1'b0, 6'd0, st(3'd2));
    cyc("mem_wait", 1'b0, 1'b0, 1'b0, 6'd0, st(3'd3) | RE);
    rst = 1'b1;
    cyc("rst_in_mem", 1'b1, 1'b1, 1'b1, 6'd12, 16'h0);
    rst = 1'b0;
    cyc("after_rst", 1'b0, 1'b1, 1'b0, 6'd12, st(3'd0) | REQ);

    // Random instruction stream
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      int fw, mw, r;
      r  = $urandom_range(0, 99);
      op = (r < 10) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(1, 13));
      fw = $urandom_range(0, 2);
      r  = $urandom_range(0, 9);
      if (r < 6)       mw = $urandom_range(0, 3);
      else if (r < 8)  mw = $urandom_range(int'(MEM_TO) - 2, int'(MEM_TO) - 1);
      else             mw = $urandom_range(int'(MEM_TO), int'(MEM_TO) + 3);
      run_instr(op, fw, rb(), mw, h);
      if (h) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
